// File: rtl/am29_pkg.sv
// Shared definitions for the am29xx bus-port family: default width and the
// handshake-flag update rule used by each holding register.
package am29_pkg;

    localparam int WIDTH_DEF = 8;

    typedef struct packed {
        logic flag;
        logic ovr;
    } flag_upd_t;

    // Load beats clear. A load onto a still-full register with no clear is an overrun.
    function automatic flag_upd_t flag_update(input logic load,
                                              input logic clr,
                                              input logic flag);
        flag_upd_t upd;
        upd.flag = flag;
        upd.ovr  = 1'b0;
        if (load) begin
            upd.flag = 1'b1;
            upd.ovr  = flag & ~clr;
        end else if (clr) begin
            upd.flag = 1'b0;
        end
        return upd;
    endfunction

endpackage

// File: rtl/am2950_chan.sv
// One holding channel of the am2950: data register plus full flag.
// The overrun event is combinational and is accumulated by the top level.
module am2950_chan
    import am29_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             flag,
    output logic             ovr_evt
);

    flag_upd_t upd;

    always_comb begin
        upd = flag_update(~en_, clr, flag);
    end

    assign ovr_evt = upd.ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            flag <= 1'b0;
        end else begin
            if (!en_) begin
                q <= d;
            end
            flag <= upd.flag;
        end
    end

endmodule

// File: rtl/am2959.sv
// Tristate bus driver: passes d onto y while the active-low enable g_ is low,
// and floats y otherwise.
module am2959 #(
    parameter int WIDTH = 8
) (
    input  logic             g_,
    input  logic [WIDTH-1:0] d,
    output tri   [WIDTH-1:0] y
);

    assign y = g_ ? {WIDTH{1'bz}} : d;

endmodule

// File: rtl/am2950.sv
// Registered bidirectional port: R captures from a and drives b, S captures
// from b and drives a. Handshake flags fr/fs and a sticky overrun flag.
module am2950
    import am29_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic             enr_,
    input  logic             ens_,
    input  logic             oea_,
    input  logic             oeb_,
    input  logic             clrr,
    input  logic             clrs,
    output logic             fr,
    output logic             fs,
    output logic             ovr
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] s_q;
    logic             ovr_evt_r;
    logic             ovr_evt_s;

    am2950_chan #(.WIDTH(WIDTH)) u_chan_r (
        .clk     (clk),
        .rst     (rst),
        .en_     (enr_),
        .clr     (clrr),
        .d       (a),
        .q       (r_q),
        .flag    (fr),
        .ovr_evt (ovr_evt_r)
    );

    am2950_chan #(.WIDTH(WIDTH)) u_chan_s (
        .clk     (clk),
        .rst     (rst),
        .en_     (ens_),
        .clr     (clrs),
        .d       (b),
        .q       (s_q),
        .flag    (fs),
        .ovr_evt (ovr_evt_s)
    );

    // Output drivers are not gated by the flags; a stale word is still visible.
    am2959 #(.WIDTH(WIDTH)) u_drv_a (
        .g_ (oea_),
        .d  (s_q),
        .y  (a)
    );

    am2959 #(.WIDTH(WIDTH)) u_drv_b (
        .g_ (oeb_),
        .d  (r_q),
        .y  (b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
        end else begin
            ovr <= ovr | ovr_evt_r | ovr_evt_s;
        end
    end

endmodule

// File: tb/tb_am2950.sv
// Randomized scoreboard bench for am2950: stimulus at the falling edge feeds a
// behavioural model; a monitor checks the ports just after each rising edge.
module tb_am2950;

    logic       clk;
    logic       rst;
    logic       enr_, ens_, oea_, oeb_, clrr, clrs;
    logic [7:0] a_drv, b_drv;
    logic       a_en, b_en;
    wire  [7:0] a;
    wire  [7:0] b;
    logic       fr, fs, ovr;

    assign a = a_en ? a_drv : 8'hzz;
    assign b = b_en ? b_drv : 8'hzz;

    am2950 #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .enr_ (enr_),
        .ens_ (ens_),
        .oea_ (oea_),
        .oeb_ (oeb_),
        .clrr (clrr),
        .clrs (clrs),
        .fr   (fr),
        .fs   (fs),
        .ovr  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] s;
        logic       fr;
        logic       fs;
        logic       ovr;
        logic       chk_a;
        logic       chk_b;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: the two holding registers and three flags.
    logic [7:0] m_r, m_s;
    logic       m_fr, m_fs, m_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_r = 8'h00; m_s = 8'h00;
        m_fr = 1'b0; m_fs = 1'b0; m_ovr = 1'b0;
    endtask

    // Apply one cycle of stimulus (called at a falling edge) and push what the
    // ports must show after the following rising edge.
    task automatic step(input logic er, input logic es, input logic cr, input logic cs,
                        input logic oa, input logic ob, input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] bus_a, bus_b;
        exp_t e;
        enr_ = er; ens_ = es; clrr = cr; clrs = cs; oea_ = oa; oeb_ = ob;
        a_drv = av; b_drv = bv;
        a_en = oa; b_en = ob;
        bus_a = oa ? av : m_s;
        bus_b = ob ? bv : m_r;
        if (!er) begin
            if (m_fr && !cr) m_ovr = 1'b1;
            m_r = bus_a;
            m_fr = 1'b1;
        end else if (cr) begin
            m_fr = 1'b0;
        end
        if (!es) begin
            if (m_fs && !cs) m_ovr = 1'b1;
            m_s = bus_b;
            m_fs = 1'b1;
        end else if (cs) begin
            m_fs = 1'b0;
        end
        e.r = m_r; e.s = m_s; e.fr = m_fr; e.fs = m_fs; e.ovr = m_ovr;
        e.chk_a = ~oa; e.chk_b = ~ob;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle(input logic oa, input logic ob);
        @(negedge clk);
        step(1, 1, 0, 0, oa, ob, 8'h00, 8'h00);
    endtask

    // Asynchronous reset between edges, with loads requested to show reset wins.
    task automatic async_reset_check(input string tag);
        @(negedge clk);
        enr_ = 0; ens_ = 0; clrr = 0; clrs = 0;
        oea_ = 0; oeb_ = 0; a_en = 0; b_en = 0;
        #2 rst = 1'b1;
        #1;
        chk({tag, "_a"}, a, 8'h00);
        chk({tag, "_b"}, b, 8'h00);
        chk({tag, "_flags"}, {5'd0, fr, fs, ovr}, 8'h00);
        @(posedge clk);
        #2;
        chk({tag, "_hold_b"}, b, 8'h00);
        chk({tag, "_hold_flags"}, {5'd0, fr, fs, ovr}, 8'h00);
        @(negedge clk);
        enr_ = 1; ens_ = 1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fr", {7'd0, fr}, {7'd0, e.fr});
                chk("fs", {7'd0, fs}, {7'd0, e.fs});
                chk("ovr", {7'd0, ovr}, {7'd0, e.ovr});
                if (e.chk_a) chk("a_from_s", a, e.s);
                if (e.chk_b) chk("b_from_r", b, e.r);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int budget;
        rst = 1'b1;
        enr_ = 1; ens_ = 1; clrr = 0; clrs = 0;
        oea_ = 0; oeb_ = 0; a_en = 0; b_en = 0;
        a_drv = 8'h00; b_drv = 8'h00;
        model_reset();
        #3;
        chk("rst_a", a, 8'h00);
        chk("rst_b", b, 8'h00);
        chk("rst_flags", {5'd0, fr, fs, ovr}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // A to B transfer, then consumer clear
        @(negedge clk); step(0, 1, 0, 0, 1, 1, 8'hA5, 8'h00);
        idle_cycle(1, 0);
        @(negedge clk); step(1, 1, 1, 0, 1, 0, 8'h00, 8'h00);
        // B to A transfer
        @(negedge clk); step(1, 0, 0, 0, 1, 1, 8'h00, 8'h3C);
        idle_cycle(0, 0);
        // Back-to-back loads give an overrun that survives a clear
        @(negedge clk); step(0, 1, 0, 0, 1, 1, 8'h11, 8'h00);
        @(negedge clk); step(0, 1, 0, 0, 1, 1, 8'h22, 8'h00);
        idle_cycle(1, 0);
        @(negedge clk); step(1, 1, 1, 1, 0, 0, 8'h00, 8'h00);
        async_reset_check("rst_mid1");
        // Load and clear collide: load wins, no overrun
        @(negedge clk); step(0, 1, 0, 0, 1, 1, 8'h55, 8'h00);
        @(negedge clk); step(0, 1, 1, 0, 1, 1, 8'hF0, 8'h00);
        idle_cycle(1, 0);
        // Loopback S onto a into R
        @(negedge clk); step(1, 0, 0, 1, 1, 1, 8'h00, 8'h5A);
        @(negedge clk); step(0, 1, 1, 1, 0, 1, 8'h00, 8'h00);
        idle_cycle(0, 0);
        async_reset_check("rst_mid2");

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 99) == 0) async_reset_check("rst_rand");
        end
        idle_cycle(0, 0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) chk("drain", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/am2950.md
# am2950

Registered bidirectional 8-bit I/O port with handshake flags, modelled on the Am2950, single-clock variant. Captures data arriving on the A bus into register R and data arriving on the B bus into register S, and drives each register back out onto the opposite bus through tristate stages. It is the receiving/holding end of a bus whose transmit side is the am2959 tristate driver. Flags FR/FS tell the consumer on each side that a word is waiting.

## Interface
- WIDTH, 8, data width of both buses and registers
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- a  inout  WIDTH  A bus: R captures from it; driven from S when oea_=0
- b  inout  WIDTH  B bus: S captures from it; driven from R when oeb_=0
- enr_  input  1  active-low load enable for R (A→R)
- ens_  input  1  active-low load enable for S (B→S)
- oea_  input  1  active-low output enable, S onto a
- oeb_  input  1  active-low output enable, R onto b
- clrr  input  1  synchronous clear of FR (consumer on B side has taken R)
- clrs  input  1  synchronous clear of FS (consumer on A side has taken S)
- fr  output  1  R full flag
- fs  output  1  S full flag
- ovr  output  1  sticky overrun: a load hit a register whose flag was still set

## Operation
- Two identical channels: R channel (a→R→b, enr_, clrr, fr) and S channel (b→S→a, ens_, clrs, fs).
- Load: at the rising clk edge with en_=0, register ← sampled bus value; flag ← 1.
- Clear: at the edge with clr=1 and en_=1, flag ← 0; register keeps its value.
- Load and clear in the same cycle: load wins; flag stays/becomes 1. The cycle is not counted as an overrun.
- Overrun: load with flag already 1 and clr=0 sets ovr. ovr stays set until rst. The register is still overwritten.
- Output: a = oea_ ? 'z : S; b = oeb_ ? 'z : R. Purely combinational from the registers, with no gating by the flags.
- Loopback: enr_=0 with oea_=0 is legal. R captures S, because a carries S. The same applies to ens_=0 with oeb_=0.
- A bus value containing x/z is captured as-is. No filtering.

## Timing
- Reset, asynchronous: R=0, S=0, fr=0, fs=0, ovr=0 immediately. Bus drive still follows the oe inputs, so a or b shows 0 if enabled.
- Load latency is 1 edge. The new R value appears on b and fr=1 in the same delta after the capturing edge.
- Output-enable changes take effect combinationally, with zero cycles of latency.
- rst asserted mid-transfer wins over any load or clear in that cycle. The first load after rst release behaves as a fresh load: flag 0→1, no overrun.
- Back-to-back loads on consecutive cycles with no clear in between: the second load sets ovr.

## Structure
- Shared package am29_pkg holds the WIDTH default constant and a flag-update function (load, clr, flag) → {next_flag, overrun_event}.
- One natural sub-module, am2950_chan (register + flag + overrun event), is instantiated twice.
- The output stage reuses am2959 with .WIDTH(WIDTH): g_ is tied to oea_ or oeb_.
- ovr is the OR-accumulation of both channels' overrun events into a single top-level flop.

## Test plan
- Reset: rst=1 with oea_=oeb_=0 → a=b=8'h00, fr=fs=ovr=0. With oea_=oeb_=1 → a=b=z.
- A→B transfer: drive a=8'hA5, enr_=0 for 1 cycle, then oeb_=0 → b=8'hA5, fr=1. Pulse clrr → fr=0, b stays 8'hA5.
- B→A transfer: drive b=8'h3C, ens_=0 for 1 cycle, oea_=0 → a=8'h3C, fs=1, fr unchanged.
- Overrun: load R with 8'h11, then load 8'h22 the next cycle without clrr → R=8'h22, fr=1, ovr=1. ovr stays 1 after clrr; it clears only on rst.
- Load+clear collision: fr=1, enr_=0 and clrr=1 in the same cycle with a=8'hF0 → R=8'hF0, fr=1, ovr unchanged (0).
- Loopback and async reset: S=8'h5A, oea_=0, enr_=0 → R=8'h5A after 1 edge. Assert rst between edges → R=S=0 and flags 0 without waiting for clk.
